// File: rtl/dram_sel_scan.sv
// Scan engine: walks a source DRAM address window, filters each word through a
// selectable predicate, and packs matches into a catch DRAM. Macro DRAM_SEL_SCAN_TAG_EN adds the source address to wd.
module dram_sel_scan #(
  parameter int D_WIDTH = 4,
  parameter int A_WIDTH = 15,
  parameter int C_WIDTH = 15,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [A_WIDTH-1:0] start_addr,
  input  logic [A_WIDTH-1:0] end_addr,
  input  logic [1:0]         mode,
  input  logic [D_WIDTH-1:0] ref_a,
  input  logic [D_WIDTH-1:0] ref_b,
  output logic               rce,
  output logic [A_WIDTH-1:0] ra,
  input  logic [D_WIDTH-1:0] rq,
  output logic               wce,
  output logic [C_WIDTH-1:0] wa,
`ifdef DRAM_SEL_SCAN_TAG_EN
  output logic [A_WIDTH+D_WIDTH-1:0] wd,
`else
  output logic [D_WIDTH-1:0] wd,
`endif
  output logic               busy,
  output logic               done,
  output logic [C_WIDTH:0]   match_count,
  output logic               overflow,
  output logic               aborted
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t             state_reg;
  logic [A_WIDTH-1:0] end_reg;
  logic [1:0]         mode_reg;
  logic [D_WIDTH-1:0] ref_a_reg;
  logic [D_WIDTH-1:0] ref_b_reg;
  logic [RD_LAT-1:0]  vld_reg;
  logic [RD_LAT-1:0]  vld_shl;
  logic               issue;
  logic               eval;
  logic               hit;
  logic               full;
  logic               wr;
  logic               drop;
  logic               fill_next;

  // The abort cycle itself must not issue a read, so the enable is gated by the live input.
  assign issue     = (state_reg == S_SCAN) && !abort;
  assign rce       = issue;
  assign eval      = vld_reg[RD_LAT-1];
  assign vld_shl   = vld_reg << 1;
  assign full      = match_count[C_WIDTH];
  assign wr        = eval && hit && !full;
  assign drop      = eval && hit && full;
  assign fill_next = wr && (&match_count[C_WIDTH-1:0]);

  always_comb begin
    hit = 1'b0;
    case (mode_reg)
      2'd0:    hit = (rq == ref_a_reg);
      2'd1:    hit = (rq >= ref_a_reg);
      2'd2:    hit = (rq >= ref_a_reg) && (rq <= ref_b_reg);
      default: hit = ((rq & ref_b_reg) == (ref_a_reg & ref_b_reg));
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_reg <= '0;
    end else begin
      vld_reg[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_reg[i] <= vld_reg[i-1];
    end
  end

`ifdef DRAM_SEL_SCAN_TAG_EN
  logic [A_WIDTH-1:0] tag_pipe_reg [RD_LAT];

  // Address rides alongside the read so the tag lines up with rq at evaluation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe_reg[i] <= '0;
    end else begin
      tag_pipe_reg[0] <= ra;
      for (int i = 1; i < RD_LAT; i++) tag_pipe_reg[i] <= tag_pipe_reg[i-1];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      end_reg     <= '0;
      mode_reg    <= '0;
      ref_a_reg   <= '0;
      ref_b_reg   <= '0;
      ra          <= '0;
      wce         <= 1'b0;
      wa          <= '0;
      wd          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
      overflow    <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      wce  <= 1'b0;
      done <= 1'b0;
      if (wr) begin
        wce         <= 1'b1;
        wa          <= match_count[C_WIDTH-1:0];
`ifdef DRAM_SEL_SCAN_TAG_EN
        wd          <= {tag_pipe_reg[RD_LAT-1], rq};
`else
        wd          <= rq;
`endif
        match_count <= match_count + (C_WIDTH+1)'(1);
      end
      if (drop) overflow <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            end_reg     <= end_addr;
            mode_reg    <= mode;
            ref_a_reg   <= ref_a;
            ref_b_reg   <= ref_b;
            ra          <= start_addr;
            wa          <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
            aborted     <= 1'b0;
            busy        <= 1'b1;
            state_reg   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (abort) begin
            aborted   <= 1'b1;
            state_reg <= S_DRAIN;
          end else if (ra == end_reg || fill_next) begin
            state_reg <= S_DRAIN;
          end else begin
            ra <= ra + A_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          // Only the read being evaluated this cycle may remain in flight.
          if (vld_shl == '0) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dram_sel_scan.md
Name: dram_sel_scan

Overview:
- Parametrised scan engine that replaces the fixed testbench-driven sweep of the L1 DRAM.
- Walks a programmable address window of the source DRAM read port (rce/ra/rq), one read per cycle.
- Evaluates a selectable predicate on each returned word and writes matching words, compacted, into the catch DRAM write port (wce/wa/wd).
- Reports match count, overflow and abort status through a start/done handshake.

Parameters:
- D_WIDTH, 4, data word width.
- A_WIDTH, 15, source address width.
- C_WIDTH, 15, catch address width; catch depth = 2^C_WIDTH.
- RD_LAT, 1, source read latency in cycles (rce/ra at cycle t -> rq valid at t+RD_LAT); legal 1..4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- abort  in  1  level; stops issuing reads while busy.
- start_addr  in  A_WIDTH  first source address, latched on accepted start.
- end_addr  in  A_WIDTH  last source address (inclusive), latched on start.
- mode  in  2  predicate select, latched on start.
- ref_a  in  D_WIDTH  predicate operand A, latched on start.
- ref_b  in  D_WIDTH  predicate operand B, latched on start.
- rce  out  1  source read enable.
- ra  out  A_WIDTH  source read address.
- rq  in  D_WIDTH  source read data.
- wce  out  1  catch write enable (select strobe).
- wa  out  C_WIDTH  catch write address.
- wd  out  D_WIDTH (+A_WIDTH with tag)  catch write data.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of scan.
- match_count  out  C_WIDTH+1  matches written in the current/last scan.
- overflow  out  1  sticky per scan; the catch filled and matches were dropped.
- aborted  out  1  sticky per scan; the scan ended by abort.

Behaviour:
- Reset (async): FSM=IDLE; rce, wce, busy, done = 0; ra, wa, wd = 0; match_count = 0; overflow, aborted = 0; in-flight pipeline cleared.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - On start=1, latch operands; clear match_count, overflow and aborted; set wa=0 and busy=1; go to SCAN.
  - start while busy is ignored.
- SCAN:
  - rce=1 and ra=current address each cycle; the address increments modulo 2^A_WIDTH.
  - end_addr < start_addr wraps through 2^A_WIDTH-1 to 0.
  - start_addr == end_addr is a single read.
  - Go to DRAIN after issuing end_addr, when abort=1 (that cycle issues no read), or when the catch is full.
- DRAIN:
  - rce=0; wait until all in-flight reads (RD_LAT-deep valid shift register) have returned and been evaluated.
  - Then go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Evaluation:
  - The read issued at cycle t is evaluated at t+RD_LAT.
  - On a match: wce=1, wa=match_count[C_WIDTH-1:0], wd=word at t+RD_LAT+1 (registered).
  - match_count increments in the same cycle wce is asserted.
- Predicates, unsigned:
  - mode 0: rq==ref_a.
  - mode 1: rq>=ref_a.
  - mode 2: ref_a<=rq<=ref_b; if ref_a>ref_b nothing matches.
  - mode 3: (rq&ref_b)==(ref_a&ref_b).
- Full catch:
  - When match_count reaches 2^C_WIDTH, stop issuing reads.
  - Further in-flight matches are not written; any such dropped match sets overflow.
  - wa never wraps.
- abort during DRAIN or DONE is ignored. abort during SCAN sets aborted; in-flight reads still complete and write.
- Reset mid-scan returns to IDLE immediately; no done pulse.

Optional Feature:
- Macro: DRAM_SEL_SCAN_TAG_EN.
- Defined: wd is D_WIDTH+A_WIDTH bits = {source_address, data}. The source address travels with the read through the latency pipeline.
- Undefined: wd is D_WIDTH bits of data only, and no address pipeline is built.

Test Plan:
- Source[i]=i[3:0]; start_addr=0, end_addr=31, mode 0, ref_a=5 -> writes at wa 0,1 with data 5 (addresses 5, 21); match_count=2; done 33+RD_LAT cycles after start.
- Mode 2, ref_a=3, ref_b=6, addresses 0..15 -> 4 writes, data 3,4,5,6 in order; overflow=0.
- Wrap: start_addr=32766, end_addr=1, mode 1, ref_a=0 -> reads 32766, 32767, 0, 1; 4 writes; tag build: wd tags equal those addresses.
- C_WIDTH=2, mode 1, ref_a=0, addresses 0..15 -> exactly 4 writes (wa 0..3); reads stop; overflow=1 if any in-flight match dropped (RD_LAT≥1 -> 1); match_count=4.
- abort raised on the 6th SCAN cycle, addresses 0..99, mode 1 -> 5 reads issued; all 5 written; aborted=1; done pulses.
- start while busy -> ignored. rst asserted mid-SCAN -> all outputs 0 asynchronously; a new start afterwards runs cleanly.
